// File: rtl/name_table_writer_if.sv
// Tile-write request channel into the name table writer.
//   req_valid  : request present (master -> slave)
//   req_ready  : request accepted on a cycle where req_valid is also high (slave -> master)
//   req_row    : tile row 0..29; rows above 29 are rejected
//   req_col    : tile column 0..31
//   req_tile   : tile index to store
interface name_table_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_row;
    logic [4:0] req_col;
    logic [7:0] req_tile;

    modport master (
        output req_valid,
        output req_row,
        output req_col,
        output req_tile,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_row,
        input  req_col,
        input  req_tile,
        output req_ready
    );
endinterface

// File: rtl/name_table_writer.sv
// Name table writer: queues single-tile writes and applies them to a 32-bit
// wide name table RAM (four tiles per word) during vblank. It can also fill
// the whole table with one tile value.
//
// Ports
//   clk, rstn      : clock; synchronous active-low reset
//   req            : request channel (name_table_writer_if.slave)
//   fill_start     : one-cycle pulse, fill all 240 words (only honoured in IDLE)
//   fill_tile      : fill value, captured when the fill starts
//   vblank         : RAM writes permitted while high
//   busy           : FIFO non-empty, FSM active, or a RAM access in flight
//   err_pulse      : one-cycle flag, request with row > 29 was dropped
//   nt_addr        : RAM word index 0..239 = {row, col[4:2]}
//   nt_rd_en       : RAM read strobe; nt_rd_data is valid the following cycle
//   nt_rd_data     : RAM read data
//   nt_wr_en       : RAM write strobe
//   nt_wr_data     : RAM write word
//   nt_byte_we     : byte lane enables, bit3 = [31:24]
//
// Build option
//   NT_BYTE_WE_EN  : RAM honours byte enables; each request becomes a single
//                    byte-masked write instead of a read-modify-write.
//
// Every RAM-side output is registered. vblank is sampled at a clock edge and
// the access it permits appears on the RAM pins in the following cycle.
module name_table_writer (
    input  logic                     clk,
    input  logic                     rstn,
    name_table_writer_if.slave       req,
    input  logic                     fill_start,
    input  logic [7:0]               fill_tile,
    input  logic                     vblank,
    output logic                     busy,
    output logic                     err_pulse,
    output logic [7:0]               nt_addr,
    output logic                     nt_rd_en,
    input  logic [31:0]              nt_rd_data,
    output logic                     nt_wr_en,
    output logic [31:0]              nt_wr_data,
    output logic [3:0]               nt_byte_we
);

    localparam int unsigned ROW_W     = 5;
    localparam int unsigned COL_W     = 5;
    localparam int unsigned TILE_W    = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned MAX_ROW   = 29;
    localparam int unsigned LAST_WORD = 239;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [TILE_W-1:0] tile;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_FILL
    } state_t;

    state_t              state_q, state_d;
    entry_t              fifo_q [DEPTH];
    entry_t              fifo_head;
    entry_t              in_entry;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ready_q, busy_q, err_q;
    logic                accept, push, pop, bad_row, can_start, dispatch;
    logic [1:0]          lane_q, lane_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [TILE_W-1:0]   fill_tile_q, fill_tile_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   merged;
    logic [BE_W-1:0]     byte_we_q, byte_we_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;

    assign req.req_ready = ready_q;
    assign busy          = busy_q;
    assign err_pulse     = err_q;
    assign nt_addr       = addr_q;
    assign nt_rd_en      = rd_en_q;
    assign nt_wr_en      = wr_en_q;
    assign nt_wr_data    = wr_data_q;
    assign nt_byte_we    = byte_we_q;

    assign fifo_head = fifo_q[rd_ptr_q];
    assign in_entry  = '{row: req.req_row, col: req.req_col, tile: req.req_tile};
    assign can_start = (count_q != CNT_W'(0)) && vblank;

    // Request acceptance and FIFO occupancy; bad rows are consumed but never stored
    always_comb begin
        accept  = req.req_valid && ready_q;
        bad_row = accept && (req.req_row > ROW_W'(MAX_ROW));
        push    = accept && !bad_row;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        fill_tile_d = fill_tile_q;
        lane_d      = lane_q;
        tile_d      = tile_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        byte_we_d   = '0;
        pop         = 1'b0;
        dispatch    = 1'b0;
        merged      = nt_rd_data;

        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    state_d     = S_FILL;
                    k_d         = '0;
                    fill_tile_d = fill_tile;
                end else if (can_start) begin
                    dispatch = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_MERGE;
            end
            S_MERGE: begin
                case (lane_q)
                    2'd0:    merged[31:24] = tile_q;
                    2'd1:    merged[23:16] = tile_q;
                    2'd2:    merged[15:8]  = tile_q;
                    default: merged[7:0]   = tile_q;
                endcase
                wr_en_d   = 1'b1;
                wr_data_d = merged;
                byte_we_d = 4'b1111;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                // Chain straight into the next request to keep the 3-cycle cadence
                state_d = S_IDLE;
                if (can_start) begin
                    dispatch = 1'b1;
                end
            end
            S_FILL: begin
                if (vblank) begin
                    wr_en_d   = 1'b1;
                    byte_we_d = 4'b1111;
                    addr_d    = k_q;
                    wr_data_d = {4{fill_tile_q}};
                    if (k_q == ADDR_W'(LAST_WORD)) begin
                        state_d = S_IDLE;
                    end else begin
                        k_d = k_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pop the FIFO head and launch its RAM access
        if (dispatch) begin
            pop    = 1'b1;
            lane_d = fifo_head.col[1:0];
            tile_d = fifo_head.tile;
            addr_d = {fifo_head.row, fifo_head.col[4:2]};
`ifdef NT_BYTE_WE_EN
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_data_d = {4{fifo_head.tile}};
            byte_we_d = BE_W'(4'b1000 >> fifo_head.col[1:0]);
`else
            state_d = S_READ;
            rd_en_d = 1'b1;
`endif
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_entry;
        end
    end

    // State, FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            lane_q      <= '0;
            tile_q      <= '0;
            fill_tile_q <= '0;
            k_q         <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            byte_we_q   <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
            count_q     <= count_d;
            ready_q     <= (count_d != CNT_W'(DEPTH));
            busy_q      <= (count_d != CNT_W'(0)) || (state_d != S_IDLE) || wr_en_d || rd_en_d;
            err_q       <= bad_row;
            lane_q      <= lane_d;
            tile_q      <= tile_d;
            fill_tile_q <= fill_tile_d;
            k_q         <= k_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            byte_we_q   <= byte_we_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
        end
    end

endmodule

// File: tb/tb_name_table_writer.sv
// Directed testbench for name_table_writer with a behavioural name table RAM.
module tb_name_table_writer;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        vb;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
    } rd_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fill_start, vblank;
    logic [7:0]  fill_tile;
    logic        busy, err_pulse;
    logic [7:0]  nt_addr;
    logic        nt_rd_en, nt_wr_en;
    logic [31:0] nt_rd_data, nt_wr_data;
    logic [3:0]  nt_byte_we;

    logic [31:0] mem [0:255];
    logic        clr_en = 1'b0;
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    logic        vb_edge = 1'b0;

    wr_t wlog [$];
    rd_t rlog [$];
    int  cyc = 0;
    int  both_cnt = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    name_table_writer_if ifc ();

    name_table_writer dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (ifc),
        .fill_start (fill_start),
        .fill_tile  (fill_tile),
        .vblank     (vblank),
        .busy       (busy),
        .err_pulse  (err_pulse),
        .nt_addr    (nt_addr),
        .nt_rd_en   (nt_rd_en),
        .nt_rd_data (nt_rd_data),
        .nt_wr_en   (nt_wr_en),
        .nt_wr_data (nt_wr_data),
        .nt_byte_we (nt_byte_we)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model honouring byte enables, one-cycle read latency
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        vb_edge <= vblank;
        if (clr_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (nt_wr_en === 1'b1) begin
            for (int b = 0; b < 4; b++)
                if (nt_byte_we[b]) mem[nt_addr][b*8 +: 8] <= nt_wr_data[b*8 +: 8];
        end
        if (nt_rd_en === 1'b1) nt_rd_data <= mem[nt_addr];
    end

    // Access log, sampled mid-cycle
    always @(negedge clk) begin
        if (nt_wr_en === 1'b1) wlog.push_back('{cyc, nt_addr, nt_wr_data, nt_byte_we, vb_edge});
        if (nt_rd_en === 1'b1) rlog.push_back('{cyc, nt_addr});
        if (nt_wr_en === 1'b1 && nt_rd_en === 1'b1) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic send_req(input logic [4:0] row, input logic [4:0] col, input logic [7:0] tile,
                            output bit ok);
        ok = 1'b0;
        ifc.req_valid = 1'b1; ifc.req_row = row; ifc.req_col = col; ifc.req_tile = tile;
        for (int i = 0; i < 100; i++) begin
            if (ifc.req_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_wr(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wlog.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; vblank = 1'b0; fill_start = 1'b0; fill_tile = '0;
        ifc.req_valid = 1'b0; ifc.req_row = '0; ifc.req_col = '0; ifc.req_tile = '0;
        clr_en = 1'b1;
        tick(3);
        clr_en = 1'b0;
        n_tests++; if (ifc.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0h expected 0", ifc.req_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h expected 0", err_pulse); end
        n_tests++; if (nt_rd_en !== 1'b0 || nt_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rd=%0h wr=%0h expected 0 0", nt_rd_en, nt_wr_en); end
        n_tests++; if (nt_byte_we !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %0h expected 0", nt_byte_we); end
        n_tests++; if (nt_addr !== 8'h00 || nt_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_addr_data: got %0h %0h expected 0 0", nt_addr, nt_wr_data); end
        rstn = 1'b1;
        tick(1);
        n_tests++; if (ifc.req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %0h expected 1", ifc.req_ready); end
    endtask

    task automatic test_basic_rmw;
        bit ok;
        poke(8'd5, 32'h11223344);
        wlog.delete(); rlog.delete();
        vblank = 1'b1;
        send_req(5'd0, 5'd22, 8'hAB, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_accept: got 0 expected 1"); end
        wait_wr(1, 20, ok);
        tick(4);
        n_tests++; if (wlog.size() !== 1) begin n_fail++; $display("FAIL basic_wr_count: got %0d expected 1", wlog.size()); end
        if (wlog.size() >= 1) begin
            n_tests++; if (wlog[0].addr !== 8'd5) begin n_fail++; $display("FAIL basic_wr_addr: got %0d expected 5", wlog[0].addr); end
`ifdef NT_BYTE_WE_EN
            n_tests++; if (wlog[0].data !== 32'hABABABAB || wlog[0].be !== 4'b0010) begin n_fail++; $display("FAIL basic_wr_word: got %0h/%0h expected ababab ab/2", wlog[0].data, wlog[0].be); end
            n_tests++; if (rlog.size() !== 0) begin n_fail++; $display("FAIL basic_no_read: got %0d expected 0", rlog.size()); end
`else
            n_tests++; if (wlog[0].data !== 32'h1122AB44 || wlog[0].be !== 4'hF) begin n_fail++; $display("FAIL basic_wr_word: got %0h/%0h expected 1122ab44/f", wlog[0].data, wlog[0].be); end
            n_tests++; if (rlog.size() !== 1) begin n_fail++; $display("FAIL basic_rd_count: got %0d expected 1", rlog.size()); end
            if (rlog.size() >= 1) begin
                n_tests++; if (rlog[0].addr !== 8'd5) begin n_fail++; $display("FAIL basic_rd_addr: got %0d expected 5", rlog[0].addr); end
                n_tests++; if (wlog[0].cyc - rlog[0].cyc !== 2) begin n_fail++; $display("FAIL basic_rd_to_wr: got %0d expected 2", wlog[0].cyc - rlog[0].cyc); end
            end
`endif
        end
        n_tests++; if (mem[5] !== 32'h1122AB44) begin n_fail++; $display("FAIL basic_mem: got %0h expected 1122ab44", mem[5]); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [7:0] ea;
        vblank = 1'b0;
        wlog.delete(); rlog.delete();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (ifc.req_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL b2b_ready_%0d: got %0h expected %0h", i, ifc.req_ready, (i < 4));
            end
            ifc.req_valid = 1'b1; ifc.req_row = 5'(2 + i); ifc.req_col = 5'(4 * i + 1); ifc.req_tile = 8'(8'h10 + i);
            if (i < 4) @(negedge clk);
        end
        tick(5);
        n_tests++; if (wlog.size() !== 0 || rlog.size() !== 0) begin n_fail++; $display("FAIL b2b_no_access: got wr=%0d rd=%0d expected 0 0", wlog.size(), rlog.size()); end
        n_tests++; if (busy !== 1'b1 || ifc.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got busy=%0h ready=%0h expected 1 0", busy, ifc.req_ready); end
        vblank = 1'b1;
        ok = 1'b0;
        for (int j = 0; j < 50; j++) begin
            if (ifc.req_ready === 1'b1) begin @(negedge clk); ok = 1'b1; break; end
            @(negedge clk);
        end
        ifc.req_valid = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_fifth_accept: got 0 expected 1"); end
        wait_wr(5, 60, ok);
        tick(4);
        n_tests++; if (wlog.size() !== 5) begin n_fail++; $display("FAIL b2b_wr_count: got %0d expected 5", wlog.size()); end
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            ea = 8'((2 + i) * 8 + i);
            n_tests++; if (wlog[i].addr !== ea) begin n_fail++; $display("FAIL b2b_addr_%0d: got %0d expected %0d", i, wlog[i].addr, ea); end
            n_tests++; if (mem[ea] !== {8'h00, 8'(8'h10 + i), 16'h0000}) begin n_fail++; $display("FAIL b2b_mem_%0d: got %0h expected %0h", i, mem[ea], {8'h00, 8'(8'h10 + i), 16'h0000}); end
`ifndef NT_BYTE_WE_EN
            if (i > 0) begin
                n_tests++; if (wlog[i].cyc - wlog[i-1].cyc !== 3) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d expected 3", i, wlog[i].cyc - wlog[i-1].cyc); end
            end
`endif
        end
    endtask

    task automatic test_bad_row;
        vblank = 1'b1;
        wlog.delete(); rlog.delete();
        ifc.req_valid = 1'b1; ifc.req_row = 5'd30; ifc.req_col = 5'd0; ifc.req_tile = 8'h55;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL err_pulse_high: got %0h expected 1", err_pulse); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_fifo_empty: got busy %0h expected 0", busy); end
        @(negedge clk);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL err_pulse_one_cycle: got %0h expected 0", err_pulse); end
        n_tests++; if (ifc.req_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %0h expected 1", ifc.req_ready); end
        tick(4);
        n_tests++; if (wlog.size() !== 0 || rlog.size() !== 0) begin n_fail++; $display("FAIL err_no_access: got wr=%0d rd=%0d expected 0 0", wlog.size(), rlog.size()); end
    endtask

    task automatic test_same_word;
        bit ok;
        poke(8'd0, 32'h0);
        vblank = 1'b0;
        wlog.delete(); rlog.delete();
        send_req(5'd0, 5'd0, 8'hAA, ok);
        send_req(5'd0, 5'd3, 8'hBB, ok);
        vblank = 1'b1;
        wait_wr(2, 40, ok);
        tick(4);
        n_tests++; if (wlog.size() !== 2) begin n_fail++; $display("FAIL same_wr_count: got %0d expected 2", wlog.size()); end
        n_tests++; if (mem[0] !== 32'hAA0000BB) begin n_fail++; $display("FAIL same_word_mem: got %0h expected aa0000bb", mem[0]); end
`ifndef NT_BYTE_WE_EN
        if (wlog.size() >= 2) begin
            n_tests++; if (wlog[1].data !== 32'hAA0000BB) begin n_fail++; $display("FAIL same_word_wr1: got %0h expected aa0000bb", wlog[1].data); end
        end
`endif
    endtask

    task automatic test_fill;
        bit ok;
        int bad, first_bad;
        wlog.delete(); rlog.delete();
        vblank = 1'b1; fill_tile = 8'h07;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        tick(50);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %0h expected 1", busy); end
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        send_req(5'd3, 5'd0, 8'h42, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL fill_req_accept: got 0 expected 1"); end
        tick(30);
        vblank = 1'b0;
        tick(10);
        vblank = 1'b1;
        wait_wr(241, 400, ok);
        tick(5);
        n_tests++; if (wlog.size() !== 241) begin n_fail++; $display("FAIL fill_wr_count: got %0d expected 241", wlog.size()); end
        if (wlog.size() >= 241) begin
            bad = 0; first_bad = -1;
            for (int i = 0; i < 240; i++) begin
                if (wlog[i].addr !== 8'(i) || wlog[i].data !== 32'h07070707 || wlog[i].be !== 4'hF || wlog[i].vb !== 1'b1) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL fill_words: got %0d bad entries (first %0d) expected 0", bad, first_bad); end
            n_tests++; if (wlog[239].cyc - wlog[0].cyc !== 249) begin n_fail++; $display("FAIL fill_span: got %0d expected 249", wlog[239].cyc - wlog[0].cyc); end
            n_tests++; if (wlog[240].addr !== 8'd24) begin n_fail++; $display("FAIL fill_then_req_addr: got %0d expected 24", wlog[240].addr); end
        end
        n_tests++; if (mem[24] !== 32'h42070707) begin n_fail++; $display("FAIL fill_then_req_mem: got %0h expected 42070707", mem[24]); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n0;
        poke(8'd33, 32'h0);
        vblank = 1'b1;
        wlog.delete(); rlog.delete();
        send_req(5'd4, 5'd4, 8'h33, ok);
`ifndef NT_BYTE_WE_EN
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (nt_rd_en === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_mid_read_seen: got 0 expected 1"); end
`endif
        rstn = 1'b0;
        tick(2);
        n_tests++; if (nt_wr_en !== 1'b0 || busy !== 1'b0 || ifc.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got wr=%0h busy=%0h ready=%0h expected 0 0 0", nt_wr_en, busy, ifc.req_ready); end
        rstn = 1'b1;
        tick(8);
        n_tests++; if (wlog.size() !== 0 || mem[33] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rmw_aborted: got wr=%0d mem=%0h expected 0 0", wlog.size(), mem[33]); end
        fill_tile = 8'h5A;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        wait_wr(20, 60, ok);
        rstn = 1'b0;
        tick(1);
        n0 = wlog.size();
        tick(1);
        rstn = 1'b1;
        tick(10);
        n_tests++; if (wlog.size() !== n0) begin n_fail++; $display("FAIL rst_mid_fill_aborted: got %0d writes expected %0d", wlog.size(), n0); end
        wlog.delete();
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        wait_wr(1, 10, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL refill_started: got 0 expected 1"); end
        else begin
            n_tests++; if (wlog[0].addr !== 8'd0) begin n_fail++; $display("FAIL refill_from_zero: got %0d expected 0", wlog[0].addr); end
        end
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(2);
    endtask

`ifdef NT_BYTE_WE_EN
    task automatic test_byte_we;
        bit ok;
        vblank = 1'b1;
        wlog.delete(); rlog.delete();
        send_req(5'd1, 5'd9, 8'h5C, ok);
        wait_wr(1, 20, ok);
        tick(4);
        n_tests++; if (wlog.size() !== 1 || rlog.size() !== 0) begin n_fail++; $display("FAIL bwe_counts: got wr=%0d rd=%0d expected 1 0", wlog.size(), rlog.size()); end
        if (wlog.size() >= 1) begin
            n_tests++; if (wlog[0].addr !== 8'd10 || wlog[0].data !== 32'h5C5C5C5C || wlog[0].be !== 4'b0100) begin
                n_fail++; $display("FAIL bwe_write: got %0d/%0h/%0h expected 10/5c5c5c5c/4", wlog[0].addr, wlog[0].data, wlog[0].be);
            end
        end
    endtask
`endif

    initial begin
        rstn = 1'b0;
        test_reset;
        test_basic_rmw;
        test_back_to_back;
        test_bad_row;
        test_same_word;
        test_fill;
        test_reset_mid;
`ifdef NT_BYTE_WE_EN
        test_byte_we;
`endif
        n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
